output_stretch: RTL

OUTPUT_STRETCH -- requirements
Module: output_stretch

---
 rtl/output_stretch.sv | 99 +++++++++
 1 files changed

// File: rtl/output_stretch.sv
// Pulse stretcher: each trig event becomes one HIGH_CYCLES-wide pulse on out,
// separated by at least GAP_CYCLES idle cycles, with a bounded queue of pending events.
module output_stretch #(
   parameter int unsigned HIGH_CYCLES = 250000,
   parameter int unsigned GAP_CYCLES  = 250000,
   parameter int unsigned PEND_MAX    = 3,
   parameter logic        ACTIVE      = 1'b1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            trig,
   input  logic                            clr_ovf,
   output logic                            out,
   output logic                            busy,
   output logic [$clog2(PEND_MAX+1)-1:0]   pending,
   output logic                            overflow
);

   localparam int unsigned MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);
   localparam int unsigned PW   = $clog2(PEND_MAX + 1);

   typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   pend_n;
   logic            ovf_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         out      <= ~ACTIVE;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         out      <= (state_n == HIGH) ? ACTIVE : ~ACTIVE;
         pending  <= pend_n;
         overflow <= ovf_n;
      end
   end

   assign busy = (state != IDLE);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pending;
      ovf_n   = overflow;
      if (clr_ovf)
         ovf_n = 1'b0;
      case (state)
         IDLE: begin
            pend_n = '0;
            if (trig) begin
               state_n = HIGH;
               cnt_n   = CW'(HIGH_CYCLES - 1);
            end
         end
         HIGH, GAP: begin
            // A trig on the last GAP cycle restarts the pulse directly and never touches the queue.
            if (state == GAP && cnt == '0) begin
               if (trig) begin
                  state_n = HIGH;
                  cnt_n   = CW'(HIGH_CYCLES - 1);
               end else if (pending != '0) begin
                  state_n = HIGH;
                  cnt_n   = CW'(HIGH_CYCLES - 1);
                  pend_n  = pending - 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               if (state == HIGH && cnt == '0) begin
                  state_n = GAP;
                  cnt_n   = CW'(GAP_CYCLES - 1);
               end else begin
                  cnt_n = cnt - 1'b1;
               end
               if (trig) begin
                  if (pending < PW'(PEND_MAX))
                     pend_n = pending + 1'b1;
                  else
                     ovf_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            pend_n  = '0;
         end
      endcase
   end

endmodule
